// File: rtl/bp_fetch_unit.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Optional same-cycle update forwarding into the lookup: define BTB_BYPASS_EN.
module bp_fetch_unit #(
    parameter int               ADDR_W    = 64,
    parameter int               BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [1:0]       CTR_INIT  = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              btbValid_q  [BTB_DEPTH];
    logic [TAG_W-1:0]  btbTag_q    [BTB_DEPTH];
    logic [ADDR_W-1:0] btbTarget_q [BTB_DEPTH];
    logic [1:0]        btbCtr_q    [BTB_DEPTH];

    logic [ADDR_W-1:0] fetchPc_q;
    logic [ADDR_W-1:0] fetchPc_d;
    logic              fetchValid_q;

    logic [IDX_W-1:0]  lookupIdx;
    logic [TAG_W-1:0]  lookupTag;
    logic [IDX_W-1:0]  updIdx;
    logic [TAG_W-1:0]  updTag;
    logic              updHit;

    logic              updWrite;
    logic              newValid;
    logic [TAG_W-1:0]  newTag;
    logic [ADDR_W-1:0] newTarget;
    logic [1:0]        newCtr;

    logic              bypassHit;
    logic              lkValid;
    logic [TAG_W-1:0]  lkTag;
    logic [ADDR_W-1:0] lkTarget;
    logic [1:0]        lkCtr;
    logic              predTaken;

    // Word-offset bits of incoming PCs carry no information here.
    logic              unused_pc_bits;
    assign unused_pc_bits = ^{redirect_pc[1:0], update_pc[1:0]};

    assign lookupIdx = fetchPc_q[IDX_W+1:2];
    assign lookupTag = fetchPc_q[ADDR_W-1:IDX_W+2];
    assign updIdx    = update_pc[IDX_W+1:2];
    assign updTag    = update_pc[ADDR_W-1:IDX_W+2];
    assign updHit    = btbValid_q[updIdx] && (btbTag_q[updIdx] == updTag);

    // Post-update image of the entry selected by update_pc.
    always_comb begin
        updWrite  = 1'b0;
        newValid  = btbValid_q[updIdx];
        newTag    = btbTag_q[updIdx];
        newTarget = btbTarget_q[updIdx];
        newCtr    = btbCtr_q[updIdx];
        if (update_en) begin
            if (updHit) begin
                updWrite = 1'b1;
                if (update_taken) begin
                    newTarget = update_target;
                    newCtr    = (btbCtr_q[updIdx] == 2'b11) ? 2'b11 : btbCtr_q[updIdx] + 2'b01;
                end else begin
                    newCtr    = (btbCtr_q[updIdx] == 2'b00) ? 2'b00 : btbCtr_q[updIdx] - 2'b01;
                end
            end else if (update_taken) begin
                updWrite  = 1'b1;
                newValid  = 1'b1;
                newTag    = updTag;
                newTarget = update_target;
                newCtr    = 2'b10;
            end
        end
    end

`ifdef BTB_BYPASS_EN
    assign bypassHit = update_en && (updIdx == lookupIdx) && (updTag == lookupTag);
`else
    assign bypassHit = 1'b0;
`endif

    always_comb begin
        lkValid  = btbValid_q[lookupIdx];
        lkTag    = btbTag_q[lookupIdx];
        lkTarget = btbTarget_q[lookupIdx];
        lkCtr    = btbCtr_q[lookupIdx];
        if (bypassHit) begin
            lkValid  = newValid;
            lkTag    = newTag;
            lkTarget = newTarget;
            lkCtr    = newCtr;
        end
    end

    assign predTaken = lkValid && (lkTag == lookupTag) && lkCtr[1];

    always_comb begin
        fetchPc_d = fetchPc_q;
        if (redirect) begin
            fetchPc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
        end else if (stall) begin
            fetchPc_d = fetchPc_q;
        end else if (predTaken) begin
            fetchPc_d = lkTarget;
        end else begin
            fetchPc_d = fetchPc_q + ADDR_W'(4);
        end
    end

    // Valid bits and counters are the only BTB state needing a reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc_q    <= RESET_PC;
            fetchValid_q <= 1'b0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btbValid_q[i] <= 1'b0;
                btbCtr_q[i]   <= CTR_INIT;
            end
        end else begin
            fetchPc_q    <= fetchPc_d;
            fetchValid_q <= 1'b1;
            if (updWrite) begin
                btbValid_q[updIdx] <= newValid;
                btbCtr_q[updIdx]   <= newCtr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && updWrite) begin
            btbTag_q[updIdx]    <= newTag;
            btbTarget_q[updIdx] <= newTarget;
        end
    end

    assign fetch_pc    = fetchPc_q;
    assign fetch_valid = fetchValid_q;
    assign pred_taken  = predTaken;
    assign pred_target = predTaken ? lkTarget : '0;

endmodule
